// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one combinational-read boot ROM/memory between NumReq requesters.
// A priority port can win at most MaxPrioRun grants in a row while other ports wait.
// The other ports are served round-robin. Every accepted request gets a registered
// response one cycle later. Misaligned, out-of-range and locked-write requests are
// answered with an error and never reach the memory write enable.
module rom_arbiter #(
    parameter int unsigned NumReq        = 3,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned RomDepthWords = 4096,
    parameter int unsigned PrioReq       = 2,
    parameter int unsigned MaxPrioRun    = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumReq-1:0]             req_valid_i,
    output logic [NumReq-1:0]             req_ready_o,
    input  logic [NumReq-1:0]             req_we_i,
    input  logic [NumReq*AddrWidth-1:0]   req_addr_i,
    input  logic [NumReq*DataWidth-1:0]   req_wdata_i,
    output logic [NumReq-1:0]             rsp_valid_o,
    output logic [DataWidth-1:0]          rsp_rdata_o,
    output logic                          rsp_err_o,
    input  logic                          wr_lock_i,
    output logic                          mem_we_o,
    output logic [AddrWidth-1:0]          mem_addr_o,
    output logic [DataWidth-1:0]          mem_wdata_o,
    input  logic [DataWidth-1:0]          mem_rdata_i
);

    localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CntW = (MaxPrioRun > 0) ? $clog2(MaxPrioRun + 1) : 1;
    localparam int unsigned IdxW = AddrWidth - 2;

    logic [PtrW-1:0]      rr_ptr;
    logic [CntW-1:0]      prio_cnt;
    logic [NumReq-1:0]    rsp_valid_q;

    logic [NumReq-1:0]    rr_mask;
    logic [PtrW-1:0]      cand;
    logic [PtrW-1:0]      gnt_idx;
    logic [PtrW-1:0]      next_ptr;
    logic                 gnt_any;
    logic                 gnt_rr;
    logic                 others_valid;
    logic                 prio_cap;
    logic                 accept;
    logic                 sel_we;
    logic [AddrWidth-1:0] sel_addr;
    logic [DataWidth-1:0] sel_wdata;
    logic                 err;
    logic [NumReq-1:0]    ready;

    // Arbitration: capped strict priority first, then a round-robin scan from rr_ptr
    always_comb begin
        others_valid = 1'b0;
        for (int unsigned p = 0; p < NumReq; p++) begin
            if (p != PrioReq && req_valid_i[p]) begin
                others_valid = 1'b1;
            end
        end
        prio_cap = (prio_cnt >= CntW'(MaxPrioRun));
        rr_mask  = req_valid_i;
        // Once the cap is reached, the priority port sits out one grant if anyone else waits
        if (prio_cap && others_valid) begin
            rr_mask[PrioReq] = 1'b0;
        end
        gnt_any = 1'b0;
        gnt_rr  = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (req_valid_i[PrioReq] && !prio_cap) begin
            gnt_any = 1'b1;
            gnt_idx = PtrW'(PrioReq);
        end else begin
            for (int unsigned k = 0; k < NumReq; k++) begin
                cand = PtrW'((32'(rr_ptr) + k) % NumReq);
                if (!gnt_any && rr_mask[cand]) begin
                    gnt_any = 1'b1;
                    gnt_rr  = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
        next_ptr = (gnt_idx == PtrW'(NumReq - 1)) ? '0 : gnt_idx + PtrW'(1);
    end

    // Mux the granted port onto the memory side and check the request
    always_comb begin
        sel_we    = 1'b0;
        sel_addr  = '0;
        sel_wdata = '0;
        for (int unsigned p = 0; p < NumReq; p++) begin
            if (gnt_any && gnt_idx == PtrW'(p)) begin
                sel_we    = req_we_i[p];
                sel_addr  = req_addr_i[p*AddrWidth +: AddrWidth];
                sel_wdata = req_wdata_i[p*DataWidth +: DataWidth];
            end
        end
        err = (sel_addr[1:0] != 2'b00)
            || (sel_addr[AddrWidth-1:2] >= IdxW'(RomDepthWords))
            || (sel_we && wr_lock_i);
        accept = gnt_any && !rst_i;
        ready  = '0;
        if (accept) begin
            ready[gnt_idx] = 1'b1;
        end
    end

    assign req_ready_o = ready;
    assign mem_we_o    = accept && sel_we && !err;
    assign mem_addr_o  = sel_addr;
    assign mem_wdata_o = sel_wdata;
    // A response pending when reset arrives is suppressed immediately
    assign rsp_valid_o = rsp_valid_q & {NumReq{~rst_i}};

    // Response register, round-robin pointer and priority-run counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= '0;
            rsp_rdata_o <= '0;
            rsp_err_o   <= 1'b0;
            rr_ptr      <= '0;
            prio_cnt    <= '0;
        end else begin
            rsp_valid_q <= ready;
            if (accept) begin
                rsp_err_o   <= err;
                rsp_rdata_o <= (!sel_we && !err) ? mem_rdata_i : '0;
                if (gnt_rr) begin
                    rr_ptr <= next_ptr;
                end
                if (gnt_idx == PtrW'(PrioReq) && others_valid) begin
                    prio_cnt <= prio_cnt + CntW'(1);
                end else begin
                    prio_cnt <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter: a table of per-cycle vectors plus reset sequences.
module tb_rom_arbiter;

    logic         clk;
    logic         rst;
    logic [2:0]   req_valid;
    logic [2:0]   req_ready;
    logic [2:0]   req_we;
    logic [95:0]  req_addr;
    logic [95:0]  req_wdata;
    logic [2:0]   rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic         wr_lock;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic [31:0]  mem_rdata;

    logic [31:0]  a0, a1, a2, wd;
    logic [31:0]  mem [4096];
    logic         init_done;

    int checks;
    int errors;

    rom_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_we_i    (req_we),
        .req_addr_i  (req_addr),
        .req_wdata_i (req_wdata),
        .rsp_valid_o (rsp_valid),
        .rsp_rdata_o (rsp_rdata),
        .rsp_err_o   (rsp_err),
        .wr_lock_i   (wr_lock),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign req_addr  = {a2, a1, a0};
    assign req_wdata = {wd, wd, wd};
    assign mem_rdata = mem[mem_addr[13:2]];

    // Memory model: word k holds 0xA0000000+k, word 4 holds 0xDEADBEEF
    always @(posedge clk) begin
        if (!init_done) begin
            for (int k = 0; k < 4096; k++) mem[k] <= 32'hA000_0000 + 32'(k);
            mem[4] <= 32'hDEAD_BEEF;
        end else if (mem_we) begin
            mem[mem_addr[13:2]] <= mem_wdata;
        end
    end

    typedef struct {
        logic [2:0]  valid;
        logic [2:0]  we;
        logic [31:0] a0, a1, a2, wd;
        logic        lock;
        logic [2:0]  e_ready;
        logic        e_we;
        logic [2:0]  e_rsp;
        logic        e_err;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic [2:0] valid, input logic [2:0] we,
                       input logic [31:0] x0, input logic [31:0] x1, input logic [31:0] x2,
                       input logic [31:0] w, input logic lock,
                       input logic [2:0] e_ready, input logic e_we, input logic [2:0] e_rsp,
                       input logic e_err, input logic [31:0] e_rdata);
        vec_t v;
        v.valid = valid; v.we = we; v.a0 = x0; v.a1 = x1; v.a2 = x2; v.wd = w; v.lock = lock;
        v.e_ready = e_ready; v.e_we = e_we; v.e_rsp = e_rsp; v.e_err = e_err; v.e_rdata = e_rdata;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    initial begin
        logic [31:0] e_maddr;
        checks = 0; errors = 0;
        init_done = 1'b0;
        rst = 1'b1; wr_lock = 1'b0;
        req_valid = 3'b000; req_we = 3'b000;
        a0 = 32'h0; a1 = 32'h4; a2 = 32'h8; wd = 32'h0;

        // Reset with all ports requesting (port 0 even a legal write): nothing accepted
        @(posedge clk); #1;
        init_done = 1'b1;
        req_valid = 3'b111; req_we = 3'b001;
        #1;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_mem_we", 32'(mem_we), 32'h0);
        @(posedge clk); #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
        chk("rst_rsp_err", 32'(rsp_err), 32'h0);
        chk("rst_rsp_rdata", rsp_rdata, 32'h0);
        rst = 1'b0; req_valid = 3'b000; req_we = 3'b000;

        // Single read, round-robin, priority cap, write/read, locks, range/alignment errors
        add(3'b001, 3'b000, 32'h10, 32'h4, 32'h8, 32'h0, 1'b0, 3'b001, 1'b0, 3'b001, 1'b0, 32'hDEAD_BEEF);
        add(3'b011, 3'b000, 32'h0,  32'h4, 32'h8, 32'h0, 1'b0, 3'b010, 1'b0, 3'b010, 1'b0, 32'hA000_0001);
        add(3'b011, 3'b000, 32'h0,  32'h4, 32'h8, 32'h0, 1'b0, 3'b001, 1'b0, 3'b001, 1'b0, 32'hA000_0000);
        add(3'b011, 3'b000, 32'h0,  32'h4, 32'h8, 32'h0, 1'b0, 3'b010, 1'b0, 3'b010, 1'b0, 32'hA000_0001);
        add(3'b011, 3'b000, 32'h0,  32'h4, 32'h8, 32'h0, 1'b0, 3'b001, 1'b0, 3'b001, 1'b0, 32'hA000_0000);
        for (int i = 0; i < 4; i++)
            add(3'b111, 3'b000, 32'h0, 32'h4, 32'h8, 32'h0, 1'b0, 3'b100, 1'b0, 3'b100, 1'b0, 32'hA000_0002);
        add(3'b111, 3'b000, 32'h0,  32'h4, 32'h8, 32'h0, 1'b0, 3'b010, 1'b0, 3'b010, 1'b0, 32'hA000_0001);
        for (int i = 0; i < 4; i++)
            add(3'b111, 3'b000, 32'h0, 32'h4, 32'h8, 32'h0, 1'b0, 3'b100, 1'b0, 3'b100, 1'b0, 32'hA000_0002);
        add(3'b111, 3'b000, 32'h0,  32'h4, 32'h8, 32'h0, 1'b0, 3'b001, 1'b0, 3'b001, 1'b0, 32'hA000_0000);
        add(3'b100, 3'b100, 32'h0,  32'h4, 32'h20, 32'h1234_5678, 1'b0, 3'b100, 1'b1, 3'b100, 1'b0, 32'h0);
        add(3'b100, 3'b000, 32'h0,  32'h4, 32'h20, 32'h0, 1'b0, 3'b100, 1'b0, 3'b100, 1'b0, 32'h1234_5678);
        add(3'b100, 3'b100, 32'h0,  32'h4, 32'h20, 32'hCAFE_F00D, 1'b1, 3'b100, 1'b0, 3'b100, 1'b1, 32'h0);
        add(3'b100, 3'b000, 32'h0,  32'h4, 32'h20, 32'h0, 1'b1, 3'b100, 1'b0, 3'b100, 1'b0, 32'h1234_5678);
        add(3'b010, 3'b000, 32'h0,  32'h3, 32'h8, 32'h0, 1'b0, 3'b010, 1'b0, 3'b010, 1'b1, 32'h0);
        add(3'b001, 3'b000, 32'h4000, 32'h4, 32'h8, 32'h0, 1'b0, 3'b001, 1'b0, 3'b001, 1'b1, 32'h0);
        add(3'b001, 3'b001, 32'h4000, 32'h4, 32'h8, 32'hFFFF_FFFF, 1'b0, 3'b001, 1'b0, 3'b001, 1'b1, 32'h0);
        add(3'b000, 3'b000, 32'h0,  32'h4, 32'h8, 32'h0, 1'b0, 3'b000, 1'b0, 3'b000, 1'b1, 32'h0);
        add(3'b001, 3'b000, 32'h3FFC, 32'h4, 32'h8, 32'h0, 1'b0, 3'b001, 1'b0, 3'b001, 1'b0, 32'hA000_0FFF);

        foreach (vq[i]) begin
            req_valid = vq[i].valid; req_we = vq[i].we;
            a0 = vq[i].a0; a1 = vq[i].a1; a2 = vq[i].a2; wd = vq[i].wd;
            wr_lock = vq[i].lock;
            e_maddr = vq[i].e_ready[0] ? vq[i].a0 :
                      vq[i].e_ready[1] ? vq[i].a1 :
                      vq[i].e_ready[2] ? vq[i].a2 : 32'h0;
            #1;
            chk($sformatf("v%0d ready", i), 32'(req_ready), 32'(vq[i].e_ready));
            chk($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vq[i].e_we));
            chk($sformatf("v%0d mem_addr", i), mem_addr, e_maddr);
            @(posedge clk); #1;
            chk($sformatf("v%0d rsp_valid", i), 32'(rsp_valid), 32'(vq[i].e_rsp));
            chk($sformatf("v%0d rsp_err", i), 32'(rsp_err), 32'(vq[i].e_err));
            chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, vq[i].e_rdata);
        end

        // Write accepted, then reset: response dropped but write lands in memory
        wr_lock = 1'b0;
        req_valid = 3'b001; req_we = 3'b001; a0 = 32'h30; wd = 32'h55AA_55AA;
        #1;
        chk("mid_ready", 32'(req_ready), 32'h1);
        chk("mid_mem_we", 32'(mem_we), 32'h1);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 3'b111;
        #1;
        chk("mid_rsp_cut", 32'(rsp_valid), 32'h0);
        chk("mid_rst_ready", 32'(req_ready), 32'h0);
        chk("mid_rst_mem_we", 32'(mem_we), 32'h0);
        @(posedge clk); #1;
        chk("mid_rsp_after", 32'(rsp_valid), 32'h0);
        chk("mid_err_after", 32'(rsp_err), 32'h0);
        chk("mid_rdata_after", rsp_rdata, 32'h0);

        // After release the round-robin pointer is back at port 0
        rst = 1'b0; req_valid = 3'b011; req_we = 3'b000; a0 = 32'h30; a1 = 32'h4;
        #1;
        chk("post_ready", 32'(req_ready), 32'h1);
        @(posedge clk); #1;
        chk("post_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("post_rdata", rsp_rdata, 32'h55AA_55AA);
        req_valid = 3'b000;
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
